// File: rtl/game_if.sv
// Frame-level signals between the display/input side and the Rex-runner game controller.
interface game_if;
  logic        frame_tick;
  logic        btn_jump;
  logic [1:0]  game_state;
  logic [6:0]  dino_y;
  logic [8:0]  obstacle_x;
  logic [15:0] score;
  logic [2:0]  speed;

  modport master (
    output frame_tick, btn_jump,
    input  game_state, dino_y, obstacle_x, score, speed
  );

  modport slave (
    input  frame_tick, btn_jump,
    output game_state, dino_y, obstacle_x, score, speed
  );
endinterface

// File: rtl/game_controller.sv
// Rex-runner frame sequencer: game FSM, jump physics, obstacle scroll, collision,
// difficulty ramp and score, all advancing once per frame_tick.
module game_controller #(
  parameter int unsigned DINO_X     = 8,
  parameter int unsigned DINO_W     = 16,
  parameter int unsigned OBS_W      = 8,
  parameter int unsigned OBS_H      = 16,
  parameter int unsigned GROUND_Y   = 0,
  parameter int unsigned OBS_SPAWN  = 160,
  parameter int unsigned JUMP_V     = 8,
  parameter int unsigned SPEED_INIT = 2,
  parameter int unsigned SPEED_MAX  = 6,
  parameter int unsigned SPEED_STEP = 256,
  parameter int unsigned OVER_HOLD  = 30
) (
  input logic   clk,
  input logic   rstn,
  game_if.slave gif
);

  localparam int unsigned STEP_BITS = $clog2(SPEED_STEP);
  localparam int unsigned HOLD_W    = $clog2(OVER_HOLD + 1);

  localparam logic        [6:0]        GROUND     = 7'(GROUND_Y);
  localparam logic signed [7:0]        GROUND_S   = $signed(8'(GROUND_Y));
  localparam logic        [8:0]        SPAWN      = 9'(OBS_SPAWN);
  localparam logic        [2:0]        SPD_INIT   = 3'(SPEED_INIT);
  localparam logic        [2:0]        SPD_MAX    = 3'(SPEED_MAX);
  localparam logic        [HOLD_W-1:0] HOLD_FULL  = HOLD_W'(OVER_HOLD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [6:0]         dino_y_q, dino_y_d;
  logic signed [5:0]  vel_q, vel_d;
  logic [8:0]         obs_x_q, obs_x_d;
  logic [15:0]        score_q, score_d;
  logic [2:0]         speed_q, speed_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               btn_d_q, btn_d_d;
  logic               jump_req_q, jump_req_d;

  logic               press_c;
  logic               req_c;
  logic               grounded_c;
  logic               hit_c;
  logic signed [7:0]  y_sum_c;
  logic [15:0]        score_inc_c;

  // Shared helpers: press edge, effective request, overlap test, next score.
  always_comb begin
    press_c     = gif.btn_jump & ~btn_d_q;
    req_c       = jump_req_q | press_c;
    grounded_c  = (dino_y_q == GROUND) && (vel_q == 6'sd0);
    y_sum_c     = $signed({1'b0, dino_y_q}) + $signed({{2{vel_q[5]}}, vel_q});
    hit_c       = ({1'b0, obs_x_q} < 10'(DINO_X + DINO_W))
               && (({1'b0, obs_x_q} + 10'(OBS_W)) > 10'(DINO_X))
               && (dino_y_q < 7'(GROUND_Y + OBS_H));
    score_inc_c = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
  end

  always_comb begin
    state_d    = state_q;
    dino_y_d   = dino_y_q;
    vel_d      = vel_q;
    obs_x_d    = obs_x_q;
    score_d    = score_q;
    speed_d    = speed_q;
    hold_d     = hold_q;
    btn_d_d    = gif.btn_jump;
    // The latch is consumed by every tick; a press on the tick cycle is used via req_c.
    jump_req_d = gif.frame_tick ? 1'b0 : req_c;

    if (gif.frame_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_c) begin
            state_d  = ST_RUN;
            dino_y_d = GROUND;
            vel_d    = 6'sd0;
            obs_x_d  = SPAWN;
            score_d  = 16'd0;
            speed_d  = SPD_INIT;
          end
        end

        ST_RUN: begin
          if (hit_c) begin
            state_d = ST_OVER;
            hold_d  = '0;
          end else begin
            if (grounded_c) begin
              if (req_c) begin
                dino_y_d = dino_y_q + 7'(JUMP_V);
                vel_d    = 6'(JUMP_V - 1);
              end
            end else if (y_sum_c <= GROUND_S) begin
              dino_y_d = GROUND;
              vel_d    = 6'sd0;
            end else begin
              dino_y_d = y_sum_c[6:0];
              vel_d    = vel_q - 6'sd1;
            end

            if (obs_x_q < 9'(speed_q)) begin
              obs_x_d = SPAWN;
            end else begin
              obs_x_d = obs_x_q - 9'(speed_q);
            end

            score_d = score_inc_c;
            if ((score_inc_c[STEP_BITS-1:0] == '0) && (speed_q < SPD_MAX)) begin
              speed_d = speed_q + 3'd1;
            end
          end
        end

        ST_OVER: begin
          if (req_c && (hold_q == HOLD_FULL)) begin
            state_d  = ST_IDLE;
            dino_y_d = GROUND;
            vel_d    = 6'sd0;
            obs_x_d  = SPAWN;
          end else if (hold_q != HOLD_FULL) begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q    <= ST_IDLE;
      dino_y_q   <= GROUND;
      vel_q      <= 6'sd0;
      obs_x_q    <= SPAWN;
      score_q    <= 16'd0;
      speed_q    <= SPD_INIT;
      hold_q     <= '0;
      btn_d_q    <= 1'b0;
      jump_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dino_y_q   <= dino_y_d;
      vel_q      <= vel_d;
      obs_x_q    <= obs_x_d;
      score_q    <= score_d;
      speed_q    <= speed_d;
      hold_q     <= hold_d;
      btn_d_q    <= btn_d_d;
      jump_req_q <= jump_req_d;
    end
  end

  assign gif.game_state = state_q;
  assign gif.dino_y     = dino_y_q;
  assign gif.obstacle_x = obs_x_q;
  assign gif.score      = score_q;
  assign gif.speed      = speed_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: vector table for the jump arc, hand sequences
// for collision, OVER hold, obstacle wrap, speed ramp and reset corner cases.
module tb_game_controller;

  logic clk = 1'b0;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;

  game_if gif();

  game_controller dut (
    .clk  (clk),
    .rstn (rstn),
    .gif  (gif)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit press;
    int st;
    int y;
    int x;
    int sc;
    int sp;
  } vec_t;

  vec_t vecs[19];
  int   ytab[17] = '{8, 15, 21, 26, 30, 33, 35, 36, 36, 35, 33, 30, 26, 21, 15, 8, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int st, input int y, input int x,
                           input int sc, input int sp);
    chk({tag, "_state"}, int'(gif.game_state), st);
    chk({tag, "_dino_y"}, int'(gif.dino_y), y);
    chk({tag, "_obs_x"}, int'(gif.obstacle_x), x);
    chk({tag, "_score"}, int'(gif.score), sc);
    chk({tag, "_speed"}, int'(gif.speed), sp);
  endtask

  task automatic tick_once();
    @(negedge clk) gif.frame_tick = 1'b1;
    @(negedge clk) gif.frame_tick = 1'b0;
  endtask

  task automatic press();
    @(negedge clk) gif.btn_jump = 1'b1;
    @(negedge clk) gif.btn_jump = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rstn = 1'b1;
    @(negedge clk) rstn = 1'b0;
  endtask

  // Jump when grounded and the obstacle sits where the airborne window covers its overlap.
  task automatic auto_jump();
    int s;
    int x;
    s = int'(gif.speed);
    x = int'(gif.obstacle_x);
    if (gif.dino_y == 7'd0 && x >= 2 * s + 25 && x <= 15 * s) press();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_sp;
    rstn           = 1'b1;
    gif.frame_tick = 1'b0;
    gif.btn_jump   = 1'b0;

    vecs[0] = '{1'b1, 1, 0, 160, 0, 2};
    for (int j = 1; j <= 17; j++)
      vecs[j] = '{(j == 1) || (j == 5), 1, ytab[j-1], 160 - 2 * j, j, 2};
    vecs[18] = '{1'b0, 1, 0, 124, 18, 2};

    do_reset();
    check_out("reset", 0, 0, 160, 0, 2);

    // Start, full jump arc, ignored airborne press, then grounded.
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].press) press();
      tick_once();
      check_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].y, vecs[i].x, vecs[i].sc, vecs[i].sp);
    end

    // Collision with no jump, then OVER hold behaviour.
    do_reset();
    press();
    tick_once();
    repeat (69) tick_once();
    check_out("pre_hit", 1, 0, 22, 69, 2);
    tick_once();
    check_out("hit", 2, 0, 22, 69, 2);
    repeat (3) tick_once();
    check_out("over_freeze", 2, 0, 22, 69, 2);
    repeat (26) tick_once();
    press();
    tick_once();
    chk("over_early_press_state", int'(gif.game_state), 2);
    press();
    tick_once();
    check_out("over_restart", 0, 0, 160, 69, 2);

    // Fresh run with timed jumps: obstacle wrap and speed ramp up to saturation.
    press();
    tick_once();
    check_out("run_entry", 1, 0, 160, 0, 2);
    for (int n = 1; n <= 1300; n++) begin
      auto_jump();
      tick_once();
      exp_sp = (2 + n / 256 > 6) ? 6 : 2 + n / 256;
      chk($sformatf("ramp_state_t%0d", n), int'(gif.game_state), 1);
      chk($sformatf("ramp_score_t%0d", n), int'(gif.score), n);
      chk($sformatf("ramp_speed_t%0d", n), int'(gif.speed), exp_sp);
      if (n == 69) begin
        chk("wrap_t69_obs_x", int'(gif.obstacle_x), 22);
        chk("wrap_t69_dino_y", int'(gif.dino_y), 26);
      end
      if (n == 80) chk("wrap_t80_obs_x", int'(gif.obstacle_x), 0);
      if (n == 81) chk("wrap_t81_obs_x", int'(gif.obstacle_x), 160);
      if (failures > 20) break;
    end

    // Get airborne, then reset on a tick cycle mid-jump.
    for (int k = 0; k < 100 && gif.dino_y == 7'd0; k++) begin
      auto_jump();
      tick_once();
    end
    chk("midjump_airborne", int'(gif.dino_y != 7'd0), 1);
    @(negedge clk);
    rstn           = 1'b1;
    gif.frame_tick = 1'b1;
    @(negedge clk);
    rstn           = 1'b0;
    gif.frame_tick = 1'b0;
    check_out("mid_reset", 0, 0, 160, 0, 2);

    // A latched press is cleared by reset.
    press();
    do_reset();
    tick_once();
    chk("latch_cleared_state", int'(gif.game_state), 0);

    // A held button starts the game but never re-triggers a jump.
    @(negedge clk) gif.btn_jump = 1'b1;
    tick_once();
    chk("held_start_state", int'(gif.game_state), 1);
    tick_once();
    tick_once();
    chk("held_no_retrigger_y", int'(gif.dino_y), 0);
    chk("held_score", int'(gif.score), 2);
    @(negedge clk) gif.btn_jump = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
